// File: rtl/apbslave_regs.sv
// APB leaf responder: NREGS x DW read/write registers with wait states, byte strobes
// and a privileged-only control register. Define APBSLAVE_SLVERR_EN to report errors on PSLVERR.
module apbslave_regs #(
  parameter int AW          = 12,
  parameter int DW          = 32,
  parameter int NREGS       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [AW-1:0]     PADDR,
  input  logic              PWRITE,
  input  logic [DW-1:0]     PWDATA,
  input  logic [DW/8-1:0]   PWSTRB,
  input  logic [2:0]        PPROT,
  output logic              PREADY,
  output logic [DW-1:0]     PRDATA,
  output logic              PSLVERR,
  output logic [DW-1:0]     o_ctrl
);

  localparam int NB  = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(NREGS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_r;
  logic [1:0]      wcnt_r;
  logic [DW-1:0]   regs_r [NREGS];

  logic [IW-1:0]   idx_s;
  logic            oor_s;
  logic            priv_err_s;
  logic            err_s;
  logic            slverr_s;
  logic            setup_s;
  logic            access_s;
  logic [DW-1:0]   rd_s;
  logic            unused_s;

  function automatic logic [DW-1:0] byte_merge(
    input logic [DW-1:0] old_v,
    input logic [DW-1:0] new_v,
    input logic [NB-1:0] strb
  );
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign unused_s = ^{PPROT[2:1], PADDR[LSB-1:0]};
  assign o_ctrl   = regs_r[0];

  // Address decode, error classification and read-data selection.
  always_comb begin
    idx_s      = PADDR[LSB+IW-1:LSB];
    oor_s      = |(PADDR >> (LSB + IW));
    priv_err_s = PWRITE && (idx_s == {IW{1'b0}}) && !PPROT[0];
    err_s      = oor_s || priv_err_s;
    setup_s    = PSEL && !PENABLE;
    access_s   = PSEL && PENABLE;
    if (err_s || PWRITE) begin
      rd_s = {DW{1'b0}};
    end else begin
      rd_s = regs_r[idx_s];
    end
`ifdef APBSLAVE_SLVERR_EN
    slverr_s = err_s;
`else
    slverr_s = 1'b0;
`endif
  end

  // Transfer sequencing with registered PREADY/PRDATA/PSLVERR.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
      wcnt_r  <= 2'd0;
      PREADY  <= 1'b0;
      PRDATA  <= {DW{1'b0}};
      PSLVERR <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          PREADY  <= 1'b0;
          PRDATA  <= {DW{1'b0}};
          PSLVERR <= 1'b0;
          if (setup_s) begin
            wcnt_r <= 2'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state_r <= ST_RESP;
              PREADY  <= 1'b1;
              PRDATA  <= rd_s;
              PSLVERR <= slverr_s;
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            // Master abandoned the transfer.
            state_r <= ST_IDLE;
            PREADY  <= 1'b0;
            PRDATA  <= {DW{1'b0}};
            PSLVERR <= 1'b0;
          end else if (PENABLE) begin
            if (wcnt_r <= 2'd1) begin
              state_r <= ST_RESP;
              PREADY  <= 1'b1;
              PRDATA  <= rd_s;
              PSLVERR <= slverr_s;
            end else begin
              wcnt_r <= wcnt_r - 2'd1;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          PREADY  <= 1'b0;
          PRDATA  <= {DW{1'b0}};
          PSLVERR <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          wcnt_r  <= 2'd0;
          PREADY  <= 1'b0;
          PRDATA  <= {DW{1'b0}};
          PSLVERR <= 1'b0;
        end
      endcase
    end
  end

  // Register bank; writes commit at the edge closing the response cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= {DW{1'b0}};
    end else if ((state_r == ST_RESP) && access_s && PWRITE && !err_s) begin
      regs_r[idx_s] <= byte_merge(regs_r[idx_s], PWDATA, PWSTRB);
    end
  end

endmodule

// File: tb/tb_apbslave_regs.sv
// Directed self-checking bench for apbslave_regs (one WAIT_STATES=1 and one WAIT_STATES=0 instance).
module tb_apbslave_regs;

`ifdef APBSLAVE_SLVERR_EN
  localparam logic SLV = 1'b1;
`else
  localparam logic SLV = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        psel = 1'b0;
  logic        psel0 = 1'b0;
  logic        penable = 1'b0;
  logic [11:0] paddr = 12'h000;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pwstrb = 4'h0;
  logic [2:0]  pprot = 3'b000;

  logic        pready, pslverr, pready0, pslverr0;
  logic [31:0] prdata, octrl, prdata0, octrl0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd;
  logic        er;

  always #5 PCLK = ~PCLK;

  apbslave_regs #(.AW(12), .DW(32), .NREGS(16), .WAIT_STATES(1)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PWSTRB(pwstrb), .PPROT(pprot),
    .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr), .o_ctrl(octrl)
  );

  apbslave_regs #(.AW(12), .DW(32), .NREGS(16), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PWSTRB(pwstrb), .PPROT(pprot),
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0), .o_ctrl(octrl0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer on the WAIT_STATES=1 instance, checking the PREADY shape.
  task automatic apb1(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p,
                      output logic [31:0] rdata, output logic err);
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d; pwstrb = s; pprot = p;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    check("pready_access1", pready, 1'b0);
    @(negedge PCLK);
    check("pready_access2", pready, 1'b1);
    rdata = prdata;
    err   = pslverr;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    check("pready_after", pready, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready", pready, 1'b0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", pslverr, 1'b0);
    check("rst_octrl", octrl, 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Full-word write then readback
    apb1(1'b1, 12'h004, 32'h12345678, 4'hF, 3'b000, rd, er);
    check("wr4_err", er, 1'b0);
    apb1(1'b0, 12'h004, 32'h0, 4'h0, 3'b000, rd, er);
    check("rd4_data", rd, 32'h12345678);
    check("rd4_err", er, 1'b0);

    // Partial strobes
    apb1(1'b1, 12'h004, 32'h11223344, 4'hF, 3'b000, rd, er);
    apb1(1'b1, 12'h004, 32'hAABBCCDD, 4'h5, 3'b000, rd, er);
    apb1(1'b0, 12'h004, 32'h0, 4'h0, 3'b000, rd, er);
    check("strb_data", rd, 32'h11BB33DD);

    // Register 0 privilege
    apb1(1'b1, 12'h000, 32'h00000001, 4'hF, 3'b000, rd, er);
    check("ctrl_unpriv_err", er, SLV);
    check("ctrl_unpriv_octrl", octrl, 32'h0);
    apb1(1'b1, 12'h000, 32'h00000001, 4'hF, 3'b001, rd, er);
    check("ctrl_priv_err", er, 1'b0);
    check("ctrl_priv_octrl", octrl, 32'h1);
    apb1(1'b0, 12'h000, 32'h0, 4'h0, 3'b000, rd, er);
    check("ctrl_unpriv_rd", rd, 32'h1);
    check("ctrl_unpriv_rd_err", er, 1'b0);

    // Out-of-range read and aliasing write
    apb1(1'b0, 12'h040, 32'h0, 4'h0, 3'b001, rd, er);
    check("oor_rd_data", rd, 32'h0);
    check("oor_rd_err", er, SLV);
    apb1(1'b1, 12'h044, 32'hDEADBEEF, 4'hF, 3'b001, rd, er);
    check("oor_wr_err", er, SLV);
    apb1(1'b0, 12'h004, 32'h0, 4'h0, 3'b000, rd, er);
    check("oor_wr_noalias", rd, 32'h11BB33DD);

    // Back-to-back writes on the zero-wait instance
    for (int k = 0; k < 3; k++) begin
      @(posedge PCLK); #1;
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; pwstrb = 4'hF; pprot = 3'b001;
      paddr = 12'h00C + 12'(4 * k);
      pwdata = 32'hA0A0_0000 + 32'(k);
      @(negedge PCLK);
      check("b2b_setup_pready", pready0, 1'b0);
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(negedge PCLK);
      check("b2b_access_pready", pready0, 1'b1);
    end
    @(posedge PCLK); #1;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010;
    @(negedge PCLK);
    check("b2b_rd_setup_pready", pready0, 1'b0);
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    check("b2b_rd_pready", pready0, 1'b1);
    check("b2b_rd_data", prdata0, 32'hA0A0_0001);
    @(posedge PCLK); #1;
    psel0 = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    check("b2b_idle_pready", pready0, 1'b0);
    check("b2b_idle_prdata", prdata0, 32'h0);

    // Reset during WAIT of a write to register 2
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h008; pwrite = 1'b1;
    pwdata = 32'hCAFEF00D; pwstrb = 4'hF; pprot = 3'b001;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check("rst_wait_pready", pready, 1'b0);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb1(1'b0, 12'h008, 32'h0, 4'h0, 3'b000, rd, er);
    check("rst_wait_reg2", rd, 32'h0);
    apb1(1'b0, 12'h004, 32'h0, 4'h0, 3'b000, rd, er);
    check("rst_cleared_reg1", rd, 32'h0);

    // Reset while PREADY is high drops it immediately
    @(posedge PCLK); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h00C; pwrite = 1'b1; pwdata = 32'h55AA55AA;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_resp_pready_hi", pready, 1'b1);
    PRESETn = 1'b0;
    #1;
    check("rst_resp_pready_lo", pready, 1'b0);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb1(1'b0, 12'h00C, 32'h0, 4'h0, 3'b000, rd, er);
    check("rst_resp_reg3", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apbslave_regs.md
# apbslave_regs

APB responder exposing a bank of NREGS DW-bit read/write registers, with programmable wait states, byte strobes, privileged-only writes to the control register, and optional PSLVERR generation. Sits behind an APB bridge as a leaf peripheral. Every transfer it completes satisfies the team's APB master/slave formal property set.

## Interface

Parameters:
- AW, 12, address width.
- DW, 32, data width; must be 32 or 64.
- NREGS, 16, number of registers; a power of two, at least 2.
- WAIT_STATES, 1, extra access cycles before PREADY; range 0..3.

Ports:
- PCLK  input  1  bus clock; all state changes on its rising edge.
- PRESETn  input  1  reset; asynchronous assert, active-low.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase marker.
- PADDR  input  AW  byte address.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  DW  write data.
- PWSTRB  input  DW/8  byte write strobes.
- PPROT  input  3  protection; only bit 0 (privileged) is used.
- PREADY  output  1  transfer complete; registered.
- PRDATA  output  DW  read data; registered.
- PSLVERR  output  1  transfer error; registered.
- o_ctrl  output  DW  live copy of register 0.

## Operation

- Register decode:
  - LSB = log2(DW/8).
  - Register index = PADDR[LSB+log2(NREGS)-1 : LSB].
  - Out of range = any PADDR bit above the index field is nonzero.
  - PADDR bits below LSB are ignored.
- States:
  - IDLE: entered on reset or after a completion.
    - PSEL=1 and PENABLE=0 (setup) → load wcnt = WAIT_STATES.
    - If WAIT_STATES=0, go to RESP; otherwise go to WAIT.
  - WAIT: while PSEL and PENABLE are high, decrement wcnt.
    - When wcnt reaches 1, go to RESP.
  - RESP: PREADY=1 for exactly one cycle, then return to IDLE.
  - PSEL low in WAIT or RESP (protocol violation): return to IDLE, no write, PREADY=0.
- Write commit, at the edge ending the RESP cycle, only if there is no error:
  - Each byte b with PWSTRB[b]=1 is updated from PWDATA.
  - Bytes with PWSTRB[b]=0 are unchanged.
- Read data: PRDATA is loaded from the addressed register on entry to RESP.
  - Zero in every other cycle.
  - Zero on an errored read.
- Error conditions:
  - Out-of-range address, read or write.
  - Write to register 0 with PPROT[0]=0.
- Errored writes never modify any register.
- Unprivileged reads of register 0 are allowed.
- Reset values: PREADY=0, PRDATA=0, PSLVERR=0, all registers 0, o_ctrl=0, state IDLE.

## Timing

- Access phase lasts WAIT_STATES+1 cycles.
- Transfer lasts WAIT_STATES+2 cycles from setup to the completing edge.
- PREADY, PSLVERR and nonzero PRDATA occur only while PSEL=1 and PENABLE=1.
- Maximum stall is WAIT_STATES cycles, below 4.
- Back-to-back transfers:
  - PREADY falls the cycle after completion.
  - A new setup may coincide with that cycle; it is accepted from IDLE with no bubble.
- o_ctrl reflects a write to register 0 the cycle after the completing edge.
- Async reset mid-transfer: all outputs clear immediately; the pending write is dropped.
- PADDR, PWRITE, PWDATA, PWSTRB and PPROT are sampled in RESP.
  - Their stability across the transfer is the master's obligation.

## Configuration

- APBSLAVE_SLVERR_EN defined:
  - Error conditions drive PSLVERR=1 in the RESP cycle.
  - Errored writes are discarded.
- APBSLAVE_SLVERR_EN undefined:
  - PSLVERR is tied to 0.
  - Errored writes are still silently discarded.
  - Errored reads return 0.

## Test plan

- Reset, WAIT_STATES=1: write 0x12345678, strobes 0xF, to PADDR 0x004.
  - PREADY high in the 2nd access cycle only.
  - A read of 0x004 then returns 0x12345678 with PSLVERR=0.
- Partial strobes: write 0xAABBCCDD with PWSTRB=0x5 over 0x11223344.
  - Readback is 0x11BB33DD.
- Register 0 privilege:
  - Write 0x1 with PPROT=0: PSLVERR=1 (with _EN), o_ctrl stays 0.
  - Repeat with PPROT=1: o_ctrl=0x1 one cycle after PREADY.
- Out-of-range: read PADDR 0x040 with NREGS=16.
  - PRDATA=0; PSLVERR=1 with _EN, 0 without.
- Back-to-back, WAIT_STATES=0: three consecutive writes with no idle between.
  - Each completes in 2 cycles.
  - PREADY pattern is 0,1,0,1,0,1.
- PRESETn pulsed low during WAIT of a write to 0x008.
  - PREADY drops immediately; register 2 reads 0 afterwards.
